pc_sequencer: RTL and testbench

//  Owns the program counter and the FETCH/EXEC state sequence of the multicycle Harvard core.

---
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch/execute sequencer bus: stall and jump-decode inputs, PC and control strobes out.
// The slave modport is the sequencer side; the master modport is the core/decoder side.
interface pc_sequencer_if;
    logic        instr_stall;
    logic        exec_stall;
    logic [1:0]  jump_sel;
    logic [31:0] rs_value;
    logic [25:0] instr_index;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        state;
    logic        fetch_en;
    logic        active;
    logic        fault;

    modport master (
        output instr_stall, exec_stall, jump_sel, rs_value, instr_index, imm16,
        input  pc, link_addr, state, fetch_en, active, fault
    );

    modport slave (
        input  instr_stall, exec_stall, jump_sel, rs_value, instr_index, imm16,
        output pc, link_addr, state, fetch_en, active, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and FETCH/EXEC/HALTED sequencer with one branch delay slot.
// Optional macro PC_ALIGN_CHECK_EN: misaligned jump targets halt the core and raise a sticky fault.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   r_pend_target;
    logic [XLEN-1:0]   w_pend_target_next;
    logic              r_pending;
    logic              w_pending_next;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_target;
    logic              w_misaligned;
    logic              w_slot_fault;

    assign w_pc_plus4 = r_pc + XLEN'(4);

    // Jump target as seen from the branch instruction itself
    always_comb begin
        w_target = w_pc_plus4;
        unique case (bus.jump_sel)
            2'b01:   w_target = bus.rs_value;
            2'b10:   w_target = {w_pc_plus4[31:28], bus.instr_index, 2'b00};
            2'b11:   w_target = w_pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
            default: w_target = w_pc_plus4;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign w_misaligned = (r_pend_target[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_pending_next     = r_pending;
        w_pend_target_next = r_pend_target;
        w_slot_fault       = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (!bus.instr_stall) w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (!bus.exec_stall) begin
                    if (r_pending) begin
                        // Delay slot completes: the captured target replaces pc+4
                        w_pending_next = 1'b0;
                        if (w_misaligned) begin
                            w_slot_fault = 1'b1;
                            w_state_next = S_HALTED;
                        end else begin
                            w_pc_next    = r_pend_target;
                            w_state_next = (r_pend_target == HALT_ADDR) ? S_HALTED : S_FETCH;
                        end
                    end else begin
                        w_pc_next    = w_pc_plus4;
                        w_state_next = (w_pc_plus4 == HALT_ADDR) ? S_HALTED : S_FETCH;
                        if (bus.jump_sel != 2'b00) begin
                            w_pending_next     = 1'b1;
                            w_pend_target_next = w_target;
                        end
                    end
                end
            end
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_VECTOR;
            r_pending     <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pending     <= w_pending_next;
            r_pend_target <= w_pend_target_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_fault <= 1'b0;
        else if (w_slot_fault) r_fault <= 1'b1;
    end

    assign bus.fault = r_fault;
`else
    logic w_unused_fault;
    assign w_unused_fault = w_slot_fault;
    assign bus.fault      = 1'b0;
`endif

    assign bus.pc        = r_pc;
    assign bus.link_addr = r_pc + XLEN'(8);
    assign bus.state     = (r_state == S_EXEC);
    assign bus.fetch_en  = (r_state == S_FETCH);
    assign bus.active    = (r_state != S_HALTED);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against an
// instruction-level reference model (phase + queue of outstanding jump targets).
module tb_pc_sequencer;
    localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if bus();
    pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 = fetch, 1 = exec, 2 = halted
    logic [31:0] m_pc;
    int          m_phase;
    logic [31:0] m_tq[$];
    bit          m_fault;

    function automatic void model_reset();
        m_pc    = RV;
        m_phase = 0;
        m_tq.delete();
        m_fault = 1'b0;
    endfunction

    function automatic void model_step(input logic is, input logic es, input logic [1:0] js,
                                       input logic [31:0] rs, input logic [25:0] idx,
                                       input logic [15:0] imm);
        logic [31:0] base;
        logic [31:0] t;
        int          off;
        if (m_phase == 0) begin
            if (!is) m_phase = 1;
        end else if (m_phase == 1 && !es) begin
            if (m_tq.size() != 0) begin
                t = m_tq.pop_front();
                if (ALIGN && (t % 4) != 0) begin
                    m_fault = 1'b1;
                    m_phase = 2;
                    return;
                end
                m_pc = t;
            end else begin
                base = m_pc + 32'd4;
                off  = int'($signed(imm)) * 4;
                case (js)
                    2'd1: m_tq.push_back(rs);
                    2'd2: m_tq.push_back((base & 32'hF000_0000) | (32'(idx) * 32'd4));
                    2'd3: m_tq.push_back(base + 32'(off));
                    default: ;
                endcase
                m_pc = base;
            end
            m_phase = (m_pc == 32'd0) ? 2 : 0;
        end
    endfunction

    task automatic tick(input logic is, input logic es, input logic [1:0] js,
                        input logic [31:0] rs, input logic [25:0] idx, input logic [15:0] imm);
        bus.instr_stall = is;
        bus.exec_stall  = es;
        bus.jump_sel    = js;
        bus.rs_value    = rs;
        bus.instr_index = idx;
        bus.imm16       = imm;
        @(posedge clk);
        #1;
        model_step(is, es, js, rs, idx, imm);
    endtask

    task automatic apply_reset();
        bus.instr_stall = 1'b0;
        bus.exec_stall  = 1'b0;
        bus.jump_sel    = 2'b00;
        bus.rs_value    = '0;
        bus.instr_index = '0;
        bus.imm16       = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({bus.pc, bus.link_addr} !== {RV, RV + 32'd8}) begin
            n_fail++; $display("FAIL reset_pc got %h/%h exp %h/%h", bus.pc, bus.link_addr, RV, RV + 32'd8);
        end
        n_tests++;
        if ({bus.state, bus.fetch_en, bus.active, bus.fault} !== 4'b0110) begin
            n_fail++; $display("FAIL reset_ctl got %b exp 0110", {bus.state, bus.fetch_en, bus.active, bus.fault});
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
            n_tests++;
            if ({bus.state, bus.fetch_en, bus.pc} !== {(i % 2 == 0), (i % 2 != 0), RV + 32'(4 * ((i + 1) / 2))}) begin
                n_fail++; $display("FAIL seq_%0d got st=%b fe=%b pc=%h", i, bus.state, bus.fetch_en, bus.pc);
            end
        end
    endtask

    // BEQ at BFC00010 with imm16=3; ds_js is the (ignored) jump decoded in the delay slot
    task automatic run_beq(input logic [1:0] ds_js, input string tag);
        apply_reset();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if (bus.pc !== 32'hBFC0_0010) begin
            n_fail++; $display("FAIL %s_pre got %h exp bfc00010", tag, bus.pc);
        end
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b11, 32'd0, 26'd0, 16'h0003);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if ({bus.state, bus.pc, bus.link_addr} !== {1'b1, 32'hBFC0_0014, 32'hBFC0_001C}) begin
            n_fail++; $display("FAIL %s_slot got st=%b pc=%h la=%h", tag, bus.state, bus.pc, bus.link_addr);
        end
        tick(1'b0, 1'b0, ds_js, 32'h0000_1000, 26'h3FF_FFFF, 16'h7FFF);
        n_tests++;
        if ({bus.state, bus.pc} !== {1'b0, 32'hBFC0_0020}) begin
            n_fail++; $display("FAIL %s_target got st=%b pc=%h exp 0/bfc00020", tag, bus.state, bus.pc);
        end
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if (bus.pc !== 32'hBFC0_0024) begin
            n_fail++; $display("FAIL %s_after got %h exp bfc00024", tag, bus.pc);
        end
    endtask

    task automatic test_branch();
        run_beq(2'b00, "beq");
    endtask

    task automatic test_delay_slot_jump();
        run_beq(2'b10, "ds_jump");
    endtask

    task automatic test_stalls();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
            n_tests++;
            if ({bus.state, bus.fetch_en, bus.pc} !== {2'b01, RV}) begin
                n_fail++; $display("FAIL istall_%0d got st=%b pc=%h", i, bus.state, bus.pc);
            end
        end
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 2'b00, 32'd0, 26'd0, 16'd0);
            n_tests++;
            if ({bus.state, bus.pc} !== {1'b1, RV}) begin
                n_fail++; $display("FAIL estall_%0d got st=%b pc=%h", i, bus.state, bus.pc);
            end
        end
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if ({bus.state, bus.pc} !== {1'b0, RV + 32'd4}) begin
            n_fail++; $display("FAIL stall_resume got st=%b pc=%h", bus.state, bus.pc);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b01, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if ({bus.active, bus.state, bus.pc} !== {2'b11, RV + 32'd4}) begin
            n_fail++; $display("FAIL halt_slot got act=%b st=%b pc=%h", bus.active, bus.state, bus.pc);
        end
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({bus.active, bus.state, bus.fetch_en, bus.pc} !== {3'b000, 32'd0}) begin
                n_fail++; $display("FAIL halted_%0d got act=%b st=%b fe=%b pc=%h",
                                   i, bus.active, bus.state, bus.fetch_en, bus.pc);
            end
            tick(1'b0, 1'b0, 2'b01, 32'h0000_0040, 26'd5, 16'd5);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b11, 32'd0, 26'd0, 16'h0040);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if ({bus.state, bus.pc} !== {1'b1, RV + 32'd4}) begin
            n_fail++; $display("FAIL rmid_pre got st=%b pc=%h", bus.state, bus.pc);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.state, bus.fetch_en, bus.pc} !== {2'b01, RV}) begin
            n_fail++; $display("FAIL rmid_async got st=%b fe=%b pc=%h", bus.state, bus.fetch_en, bus.pc);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
        if ({bus.state, bus.pc} !== {1'b0, RV + 32'd8}) begin
            n_fail++; $display("FAIL rmid_after got st=%b pc=%h exp 0/%h", bus.state, bus.pc, RV + 32'd8);
        end
    endtask

    task automatic test_misaligned();
        apply_reset();
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b01, 32'h0000_0102, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 16'd0);
        n_tests++;
`ifdef PC_ALIGN_CHECK_EN
        if ({bus.fault, bus.active, bus.state, bus.fetch_en} !== 4'b1000) begin
            n_fail++; $display("FAIL misalign got flt=%b act=%b st=%b fe=%b",
                               bus.fault, bus.active, bus.state, bus.fetch_en);
        end
`else
        if ({bus.fault, bus.active, bus.pc} !== {2'b01, 32'h0000_0102}) begin
            n_fail++; $display("FAIL misalign got flt=%b act=%b pc=%h exp 0/1/00000102",
                               bus.fault, bus.active, bus.pc);
        end
`endif
    endtask

    task automatic test_random();
        logic        is, es;
        logic [1:0]  js;
        logic [31:0] rs;
        int          r;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if (m_phase == 2 && ($urandom % 4) == 0) apply_reset();
            is = (($urandom % 4) == 0);
            es = (($urandom % 4) == 0);
            js = 2'($urandom);
            r  = int'($urandom % 16);
            rs = (r == 0) ? 32'd0 : (r == 1) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick(is, es, js, rs, 26'($urandom), 16'($urandom));
            n_tests++;
            if ({bus.pc, bus.link_addr, bus.state, bus.fetch_en, bus.active, bus.fault} !==
                {m_pc, m_pc + 32'd8, (m_phase == 1), (m_phase == 0), (m_phase != 2), m_fault}) begin
                n_fail++;
                $display("FAIL rand_c%0d got pc=%h st=%b fe=%b act=%b flt=%b exp pc=%h phase=%0d flt=%b",
                         c, bus.pc, bus.state, bus.fetch_en, bus.active, bus.fault, m_pc, m_phase, m_fault);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.instr_stall = 1'b0;
        bus.exec_stall  = 1'b0;
        bus.jump_sel    = 2'b00;
        bus.rs_value    = '0;
        bus.instr_index = '0;
        bus.imm16       = '0;
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_delay_slot_jump();
        test_stalls();
        test_halt();
        test_reset_mid();
        test_misaligned();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
